// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and spcon control-bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by both the SPI master and the SPI slave so the control word layout stays consistent.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  // spcon bit positions; all other spcon bits are don't-care
  localparam int unsigned SPCON_ENABLE = 6;
  localparam int unsigned SPCON_CPOL   = 2;
  localparam int unsigned SPCON_CPHA   = 1;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
// Latency: 2 clk from d_i change to q_o change.
// Backpressure: none; free-running.
// Ports: clk/rst_n (system clock, async active-low reset), d_i (async input), q_o (synchronized output).
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four cpol/cpha modes, oversampling sck/ssn/mosi in the clk domain.
// Latency: data_r_s/data_finish_s update 3 clk after the 8th sample edge on the sck pin.
// Backpressure: none; the master paces transfers, and each sck phase must span >= 3 clk.
// Ports: clk, rst_n; spcon (control), data_s (tx byte); sck/ssn/mosi (SPI in);
//        miso/miso_oe (SPI out); data_r_s (rx byte), data_finish_s (rx strobe).
module spi_slave
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] spcon,
  input  logic [7:0] data_s,
  input  logic       sck,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] data_r_s,
  output logic       data_finish_s
);

  logic sck_s, ssn_s, mosi_s;

  spi_sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .d_i(sck),  .q_o(sck_s));
  spi_sync2 #(.RST_VAL(1'b1)) u_sync_ssn  (.clk(clk), .rst_n(rst_n), .d_i(ssn),  .q_o(ssn_s));
  spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s));

  spi_state_e state_q, state_d;
  logic       sck_prev_q, sck_prev_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // hold: next shift edge presents tx[7] instead of advancing (cpha=1 first leading edge)
  logic       hold_q, hold_d;
  // reload: a byte has completed; next shift edge loads data_s for the following byte
  logic       reload_q, reload_d;
  logic [7:0] data_r_q, data_r_d;
  logic       finish_q, finish_d;

  logic sck_chg, lead_edge, trail_edge, sample_edge, shift_edge, abort;
  logic unused_spcon;

  assign unused_spcon = ^{spcon[7], spcon[5:3], spcon[0]};

  always_comb begin
    sck_chg     = sck_s ^ sck_prev_q;
    lead_edge   = sck_chg && (sck_s != cpol_q);
    trail_edge  = sck_chg && (sck_s == cpol_q);
    sample_edge = cpha_q ? trail_edge : lead_edge;
    shift_edge  = cpha_q ? lead_edge  : trail_edge;
    // deselect or disable ends the transfer; it outranks any same-clk sample edge
    abort       = ssn_s || !spcon[SPCON_ENABLE];
  end

  always_comb begin
    state_d    = state_q;
    sck_prev_d = sck_s;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    hold_d     = hold_q;
    reload_d   = reload_q;
    data_r_d   = data_r_q;
    finish_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ssn_s && spcon[SPCON_ENABLE]) begin
          state_d = ST_LOAD;
          cpol_d  = spcon[SPCON_CPOL];
          cpha_d  = spcon[SPCON_CPHA];
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_SHIFT;
          tx_d      = data_s;
          rx_d      = 8'h00;
          bit_cnt_d = 3'd0;
          hold_d    = cpha_q;
          reload_d  = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (sample_edge) begin
            rx_d      = {rx_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_r_d = {rx_q[6:0], mosi_s};
              finish_d = 1'b1;
              reload_d = 1'b1;
            end
          end
          // sample and shift edges are mutually exclusive in a single clk
          if (shift_edge) begin
            if (reload_q) begin
              tx_d     = data_s;
              reload_d = 1'b0;
              hold_d   = 1'b0;
            end else if (hold_q) begin
              hold_d = 1'b0;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sck_prev_q <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      hold_q     <= 1'b0;
      reload_q   <= 1'b0;
      data_r_q   <= 8'h00;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_prev_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      reload_q   <= reload_d;
      data_r_q   <= data_r_d;
      finish_q   <= finish_d;
    end
  end

  // During LOAD tx_q is not yet written, so present data_s[7] directly to make the
  // first bit visible from the LOAD cycle onward.
  always_comb begin
    miso_oe = (state_q != ST_IDLE);
    case (state_q)
      ST_LOAD:  miso = data_s[7];
      ST_SHIFT: miso = tx_q[7];
      default:  miso = 1'b0;
    endcase
  end

  assign data_r_s      = data_r_q;
  assign data_finish_s = finish_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives sck/ssn/mosi on the
// falling clk edge and samples miso; slave strobes and output enable are logged on
// the falling clk edge and compared against hand-computed values.
module tb_spi_slave;

  localparam int HALF = 5;  // clk periods per sck phase

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] spcon;
  logic [7:0] data_s;
  logic       sck, ssn, mosi;
  logic       miso, miso_oe;
  logic [7:0] data_r_s;
  logic       data_finish_s;

  logic cpol, cpha;
  int   total = 0;
  int   bad   = 0;
  int   pcnt   = 0;   // total data_finish_s pulses seen
  int   oe_cnt = 0;   // total clk cycles with miso_oe high
  logic [7:0] rec [0:63];

  spi_slave dut (
    .clk(clk), .rst_n(rst_n), .spcon(spcon), .data_s(data_s),
    .sck(sck), .ssn(ssn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .data_r_s(data_r_s), .data_finish_s(data_finish_s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_finish_s) begin
      if (pcnt < 64) rec[pcnt] = data_r_s;
      pcnt = pcnt + 1;
    end
    if (miso_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic set_mode(input logic en, input logic pol, input logic pha);
    cpol  = pol;
    cpha  = pha;
    spcon = {1'b0, en, 3'b000, pol, pha, 1'b0};
  endtask

  task automatic begin_sel();
    sck = cpol;
    repeat (4) @(negedge clk);
    ssn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic end_sel();
    half();
    ssn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mtx, output logic [7:0] mrx);
    mrx = 8'h00;
    if (!cpha) begin
      mosi = mtx[7];
      for (int i = 0; i < 8; i++) begin
        half(); sck = ~cpol; mrx = {mrx[6:0], miso};
        half(); sck = cpol;  if (i < 7) mosi = mtx[6-i];
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        half(); sck = ~cpol; mosi = mtx[7-i];
        half(); sck = cpol;  mrx = {mrx[6:0], miso};
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ssn = 1'b1; sck = 1'b0; mosi = 1'b0; data_s = 8'h00;
    set_mode(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", miso_oe); end
    total++; if (data_r_s !== 8'h00) begin bad++; $display("FAIL reset_data_r got=%h exp=00", data_r_s); end
    total++; if (data_finish_s !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b exp=0", data_finish_s); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL idle_oe got=%b exp=0", miso_oe); end
  endtask

  task automatic run_byte(input string name, input logic pol, input logic pha,
                          input logic [7:0] mtx, input logic [7:0] stx);
    logic [7:0] mrx;
    int p0;
    set_mode(1'b1, pol, pha);
    data_s = stx;
    p0 = pcnt;
    begin_sel();
    xfer(mtx, mrx);
    end_sel();
    total++; if (data_r_s !== mtx) begin bad++; $display("FAIL %s_slave_rx got=%h exp=%h", name, data_r_s, mtx); end
    total++; if (mrx !== stx) begin bad++; $display("FAIL %s_master_rx got=%h exp=%h", name, mrx, stx); end
    total++; if (pcnt - p0 !== 1) begin bad++; $display("FAIL %s_pulses got=%0d exp=1", name, pcnt - p0); end
  endtask

  task automatic test_mode0();
    run_byte("mode0", 1'b0, 1'b0, 8'hA5, 8'h3C);
  endtask

  task automatic test_modes123();
    run_byte("mode1", 1'b0, 1'b1, 8'h81, 8'h7E);
    run_byte("mode2", 1'b1, 1'b0, 8'h81, 8'h7E);
    run_byte("mode3", 1'b1, 1'b1, 8'h81, 8'h7E);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1;
    int p0;
    logic got;
    set_mode(1'b1, 1'b0, 1'b0);
    data_s = 8'h9A;
    p0 = pcnt;
    got = 1'b0;
    begin_sel();
    fork
      begin
        xfer(8'h12, r0);
        xfer(8'h34, r1);
      end
      begin
        for (int n = 0; n < 400; n++) begin
          @(negedge clk);
          if (data_finish_s) begin got = 1'b1; break; end
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL b2b_first_pulse got=timeout exp=pulse"); end
        data_s = 8'h56;
      end
    join
    end_sel();
    total++; if (pcnt - p0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pcnt - p0); end
    total++; if (rec[p0] !== 8'h12) begin bad++; $display("FAIL b2b_rx0 got=%h exp=12", rec[p0]); end
    total++; if (rec[p0+1] !== 8'h34) begin bad++; $display("FAIL b2b_rx1 got=%h exp=34", rec[p0+1]); end
    total++; if (r0 !== 8'h9A) begin bad++; $display("FAIL b2b_master0 got=%h exp=9a", r0); end
    total++; if (r1 !== 8'h56) begin bad++; $display("FAIL b2b_master1 got=%h exp=56", r1); end
  endtask

  task automatic test_abort();
    int p0;
    set_mode(1'b1, 1'b0, 1'b0);
    data_s = 8'hF0;
    p0 = pcnt;
    begin_sel();
    mosi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      half(); sck = ~sck;
    end
    half();
    ssn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL abort_oe got=%b exp=0", miso_oe); end
    sck = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (pcnt - p0 !== 0) begin bad++; $display("FAIL abort_pulses got=%0d exp=0", pcnt - p0); end
    total++; if (data_r_s !== 8'h34) begin bad++; $display("FAIL abort_data_r got=%h exp=34", data_r_s); end
    run_byte("after_abort", 1'b0, 1'b0, 8'h5A, 8'hC6);
  endtask

  task automatic test_reset_mid();
    logic [7:0] mrx;
    int p0;
    set_mode(1'b1, 1'b0, 1'b0);
    data_s = 8'hFF;
    begin_sel();
    mosi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half(); sck = ~sck;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL rst_mid_miso got=%b exp=0", miso); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe got=%b exp=0", miso_oe); end
    total++; if (data_r_s !== 8'h00) begin bad++; $display("FAIL rst_mid_data_r got=%h exp=00", data_r_s); end
    total++; if (data_finish_s !== 1'b0) begin bad++; $display("FAIL rst_mid_finish got=%b exp=0", data_finish_s); end
    ssn = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    data_s = 8'h3C;
    p0 = pcnt;
    begin_sel();
    xfer(8'hC3, mrx);
    end_sel();
    total++; if (data_r_s !== 8'hC3) begin bad++; $display("FAIL rst_after_rx got=%h exp=c3", data_r_s); end
    total++; if (mrx !== 8'h3C) begin bad++; $display("FAIL rst_after_master got=%h exp=3c", mrx); end
    total++; if (pcnt - p0 !== 1) begin bad++; $display("FAIL rst_after_pulses got=%0d exp=1", pcnt - p0); end
  endtask

  task automatic test_disabled();
    int p0, o0;
    set_mode(1'b0, 1'b0, 1'b0);
    data_s = 8'hAA;
    sck = 1'b0;
    repeat (4) @(negedge clk);
    p0 = pcnt;
    o0 = oe_cnt;
    ssn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      half(); sck = ~sck; mosi = ~mosi;
    end
    half();
    total++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL dis_oe_cycles got=%0d exp=0", oe_cnt - o0); end
    total++; if (pcnt - p0 !== 0) begin bad++; $display("FAIL dis_pulses got=%0d exp=0", pcnt - p0); end
    ssn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes123();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_disabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 spcon  input  8  control; [6] enable, [2] cpol, [1] cpha, other bits ignored.
REQ-005 data_s  input  8  byte to transmit; sampled at each byte load.
REQ-006 sck  input  1  SPI clock from master, asynchronous to clk.
REQ-007 ssn  input  1  slave select, active low, asynchronous to clk.
REQ-008 mosi  input  1  serial data from master, MSB first.
REQ-009 miso  output  1  serial data to master, MSB first.
REQ-010 miso_oe  output  1  miso drive enable; high only while selected and enabled.
REQ-011 data_r_s  output  8  last complete received byte.
REQ-012 data_finish_s  output  1  one-clk pulse when data_r_s updates.

Function
REQ-013 sck, ssn and mosi SHALL each pass through a 2-flop synchronizer before use; sck edges are detected from synchronized current/previous values.
REQ-014 Leading edge SHALL be a synchronized sck transition away from cpol; trailing edge SHALL be the transition back to cpol.
REQ-015 Sample edge SHALL be the leading edge when cpha=0 and the trailing edge when cpha=1; shift edge is the other one.
REQ-016 FSM states: IDLE, LOAD, SHIFT.
REQ-017 IDLE -> LOAD when synchronized ssn=0 and spcon[6]=1; any other condition holds IDLE.
REQ-018 LOAD SHALL last one clk, copy data_s into the tx shift register, clear bit_cnt to 0, then go to SHIFT.
REQ-019 cpha=0: miso SHALL present tx[7] from the LOAD cycle onward, and advance one bit on each trailing edge.
REQ-020 cpha=1: miso SHALL advance to the next bit on each leading edge; the first leading edge presents tx[7].
REQ-021 On each sample edge, rx shift register SHALL become {rx[6:0], mosi_sync} and bit_cnt SHALL increment (3-bit, wraps 7->0).
REQ-022 On the sample edge where bit_cnt=7, data_r_s SHALL take {rx[6:0], mosi_sync} one clk later; data_finish_s SHALL pulse high for exactly that clk.
REQ-023 After the 8th sample edge with ssn still low, the FSM SHALL reload data_s for the next byte without returning to IDLE (cpha=0: reload on the following trailing edge; cpha=1: reload on the next leading edge).
REQ-024 Synchronized ssn rising in any state SHALL return the FSM to IDLE next clk, discard the partial byte, and produce no data_finish_s.
REQ-025 spcon[6] deasserted mid-byte SHALL behave as ssn rising.
REQ-026 miso_oe SHALL equal (state != IDLE); miso SHALL be 0 while miso_oe=0.
REQ-027 A sample edge and ssn rise seen in the same clk SHALL resolve as abort (ssn wins).
REQ-028 sck edges while in IDLE or LOAD SHALL be ignored.
REQ-029 Correct operation SHALL require each sck phase to last at least 3 clk periods (master divider >= 6 clk per sck period).
REQ-030 cpol/cpha changes SHALL only be applied in IDLE; values are latched on IDLE -> LOAD.

Reset
REQ-031 On rst_n=0: state=IDLE, synchronizers cleared to ssn=1, sck=0, mosi=0; rx=0, tx=0, bit_cnt=0.
REQ-032 Reset outputs: miso=0, miso_oe=0, data_r_s=8'h00, data_finish_s=0.
REQ-033 Reset mid-transfer SHALL discard all progress; the first byte after release starts only after a fresh ssn low is seen in IDLE.

Structure
REQ-034 FSM state encodings and spcon bit indices (ENABLE=6, CPOL=2, CPHA=1) SHALL live in a shared SPI package used by master and slave.
REQ-035 One sub-module spi_sync2 (2-flop synchronizer, parameter reset value) SHALL be instantiated three times.

Verification
REQ-036 Mode 0, master sends 8'hA5, data_s=8'h3C -> data_r_s=8'hA5, one data_finish_s pulse, master receives 8'h3C.
REQ-037 Modes 1, 2, 3 each with master 8'h81, slave 8'h7E -> both ends receive correctly, one pulse per byte.
REQ-038 Two back-to-back bytes 8'h12, 8'h34 under one ssn low, data_s changed after first pulse to 8'h56 -> data_r_s 12 then 34, two pulses, master receives (first data_s) then 8'h56.
REQ-039 ssn raised after 5 sck edges -> no pulse, data_r_s unchanged, miso_oe=0 within 3 clk, next full byte received correctly.
REQ-040 rst_n pulsed low mid-byte -> all outputs at reset values immediately; subsequent transfer of 8'hC3 received intact.
REQ-041 spcon[6]=0 with ssn low and sck toggling -> miso_oe stays 0, no pulse.
